// File: rtl/trainer_session_ctrl.sv
// Session sequencer for the Braille script trainer: guest/PIN-authenticated sessions, lockout.
// Optional idle timeout is enabled by defining SESSION_TIMEOUT_EN.
module trainer_session_ctrl #(
  parameter int unsigned PIN_DIGITS  = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned LOCK_CYC    = 5000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_input,
  input  logic                    usr_ip,
  input  logic                    digit_valid,
  input  logic [3:0]              digit,
  input  logic [4*PIN_DIGITS-1:0] pin_ref,
  input  logic                    activity,
  input  logic                    logout,
  output logic                    mode_guest,
  output logic                    mode_auth,
  output logic                    session_active,
  output logic                    pin_fail,
  output logic                    locked,
  output logic [2:0]              tries_left,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPin   = 3'd1,
    StGuest = 3'd2,
    StAuth  = 3'd3,
    StLock  = 3'd4
  } state_e;

  localparam int unsigned IdxW = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              mismatch_q, mismatch_d;
  logic [2:0]        tries_q, tries_d;
  logic [31:0]       timer_q, timer_d;
  logic              pin_fail_q, pin_fail_d;
  logic              mode_guest_q, mode_auth_q, locked_q;

  logic              idle_to;
  logic              digit_bad;
  logic              last_digit;
  logic              attempt_bad;

  assign digit_bad   = (digit != pin_ref[{idx_q, 2'b00} +: 4]);
  assign last_digit  = (idx_q == IdxW'(PIN_DIGITS - 1));
  assign attempt_bad = mismatch_q | digit_bad;

`ifdef SESSION_TIMEOUT_EN
  assign idle_to = !digit_valid && !activity && (timer_q == 32'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign idle_to        = 1'b0;
  assign unused_timeout = activity ^ (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    tries_d    = tries_q;
    timer_d    = timer_q;
    pin_fail_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (load_input) begin
          if (usr_ip) begin
            state_d    = StPin;
            idx_d      = '0;
            mismatch_d = 1'b0;
          end else begin
            state_d = StGuest;
          end
        end
      end

      StPin, StGuest, StAuth: begin
`ifdef SESSION_TIMEOUT_EN
        timer_d = (digit_valid || activity) ? '0 : timer_q + 32'd1;
`else
        timer_d = '0;
`endif
        if (logout || idle_to) begin
          state_d    = StIdle;
          idx_d      = '0;
          mismatch_d = 1'b0;
          timer_d    = '0;
        end else if (state_q == StPin && digit_valid) begin
          if (!last_digit) begin
            idx_d      = idx_q + 1'b1;
            mismatch_d = attempt_bad;
          end else if (!attempt_bad) begin
            state_d    = StAuth;
            tries_d    = 3'(MAX_TRIES);
            idx_d      = '0;
            mismatch_d = 1'b0;
            timer_d    = '0;
          end else begin
            pin_fail_d = 1'b1;
            tries_d    = tries_q - 3'd1;
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (tries_q == 3'd1) begin
              state_d = StLock;
              timer_d = '0;
            end
          end
        end
      end

      StLock: begin
        if (timer_q == 32'(LOCK_CYC - 1)) begin
          state_d = StIdle;
          tries_d = 3'(MAX_TRIES);
          timer_d = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      default: begin
        state_d    = StIdle;
        idx_d      = '0;
        mismatch_d = 1'b0;
        timer_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      tries_q      <= 3'(MAX_TRIES);
      timer_q      <= '0;
      pin_fail_q   <= 1'b0;
      mode_guest_q <= 1'b0;
      mode_auth_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      tries_q      <= tries_d;
      timer_q      <= timer_d;
      pin_fail_q   <= pin_fail_d;
      mode_guest_q <= (state_d == StGuest);
      mode_auth_q  <= (state_d == StAuth);
      locked_q     <= (state_d == StLock);
    end
  end

  assign mode_guest     = mode_guest_q;
  assign mode_auth      = mode_auth_q;
  assign session_active = mode_guest_q | mode_auth_q;
  assign pin_fail       = pin_fail_q;
  assign locked         = locked_q;
  assign tries_left     = tries_q;
  assign state_o        = state_q;

endmodule
